// File: rtl/bnn_weight_streamer.sv
// rtl/bnn_weight_streamer.sv - per-channel FIFO-buffered weight feeder emitting one bit per channel per request
module bnn_weight_streamer #(
  parameter int CH     = 10,
  parameter int WORD_W = 32,
  parameter int DEPTH  = 8,
  parameter int LEN_W  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [$clog2(CH)-1:0] wr_ch,
  input  logic [WORD_W-1:0]     wr_data,
  input  logic                  start,
  input  logic [LEN_W-1:0]      layer_len,
  input  logic                  bit_en,
  output logic [CH-1:0]         bit_out,
  output logic                  bit_valid,
  output logic                  busy,
  output logic                  layer_done,
  output logic                  underrun,
  input  logic                  clr_err
);
  localparam int AW   = $clog2(DEPTH);
  localparam int IW   = $clog2(WORD_W);
  localparam int CW   = $clog2(CH);
  localparam int CNTW = AW + 1;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);
  localparam logic [IW-1:0]   LAST_IDX = IW'(WORD_W - 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;
  state_t r_state, w_state_nxt;

  logic [WORD_W-1:0] r_mem   [CH][DEPTH];
  logic [AW-1:0]     r_wptr  [CH];
  logic [AW-1:0]     r_rptr  [CH];
  logic [CNTW-1:0]   r_cnt   [CH];
  logic [WORD_W-1:0] r_shreg [CH];
  logic              r_loaded;
  logic [IW-1:0]     r_idx;
  logic [LEN_W-1:0]  r_rem;

  logic [CH-1:0] w_push;
  logic          w_all_ne;
  logic          w_consume;
  logic          w_under;
  logic          w_last;
  logic          w_word_end;
  logic          w_pop;
  logic          w_start_ok;
  logic          w_start_zero;

  // wr_ready looks at the pre-pop count, so a full FIFO stalls even while it is being drained
  always_comb begin
    wr_ready = 1'b0;
    w_all_ne = 1'b1;
    for (int c = 0; c < CH; c++) begin
      if (wr_ch == CW'(c)) wr_ready = (r_cnt[c] < FULL_CNT);
      if (r_cnt[c] == '0) w_all_ne = 1'b0;
    end
  end

  always_comb begin
    w_push = '0;
    for (int c = 0; c < CH; c++) begin
      w_push[c] = wr_valid && wr_ready && (wr_ch == CW'(c));
    end
  end

  assign busy         = (r_state == S_STREAM);
  assign w_start_ok   = (r_state == S_IDLE) && start && (layer_len != '0);
  assign w_start_zero = (r_state == S_IDLE) && start && (layer_len == '0);
  assign w_consume    = (r_state == S_STREAM) && bit_en && r_loaded;
  assign w_under      = (r_state == S_STREAM) && bit_en && !r_loaded;
  assign w_last       = w_consume && (r_rem == LEN_W'(1));
  assign w_word_end   = w_consume && (r_idx == LAST_IDX);
  // The last bit of a layer never reloads: leftover bits are dropped and the next layer starts on a fresh word
  assign w_pop        = (r_state == S_STREAM) && w_all_ne && !w_last && (!r_loaded || w_word_end);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_start_ok) w_state_nxt = S_STREAM;
      S_STREAM: if (w_last) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (w_push[c]) r_mem[c][r_wptr[c]] <= wr_data;
      if (w_pop) r_shreg[c] <= r_mem[c][r_rptr[c]];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < CH; c++) begin
        r_wptr[c] <= '0;
        r_rptr[c] <= '0;
        r_cnt[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (w_push[c]) r_wptr[c] <= r_wptr[c] + 1'b1;
        if (w_pop) r_rptr[c] <= r_rptr[c] + 1'b1;
        case ({w_push[c], w_pop})
          2'b10:   r_cnt[c] <= r_cnt[c] + 1'b1;
          2'b01:   r_cnt[c] <= r_cnt[c] - 1'b1;
          default: r_cnt[c] <= r_cnt[c];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_loaded   <= 1'b0;
      r_idx      <= '0;
      r_rem      <= '0;
      bit_out    <= '0;
      bit_valid  <= 1'b0;
      layer_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      bit_valid  <= w_consume;
      layer_done <= w_last || w_start_zero;
      if (w_start_ok)     r_rem <= layer_len;
      else if (w_consume) r_rem <= r_rem - 1'b1;
      if (w_pop) begin
        r_loaded <= 1'b1;
        r_idx    <= '0;
      end else begin
        if (w_consume) r_idx <= r_idx + 1'b1;
        if (w_last || w_word_end) r_loaded <= 1'b0;
      end
      if (w_consume) begin
        for (int c = 0; c < CH; c++) bit_out[c] <= r_shreg[c][r_idx];
      end
      if (w_under)      underrun <= 1'b1;
      else if (clr_err) underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bnn_weight_streamer.sv
// tb/tb_bnn_weight_streamer.sv - scoreboard bench for bnn_weight_streamer
`timescale 1ns/1ps
module tb_bnn_weight_streamer;
  localparam int CH     = 10;
  localparam int WORD_W = 32;
  localparam int DEPTH  = 8;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              rstn;
  logic              wr_valid;
  logic              wr_ready;
  logic [3:0]        wr_ch;
  logic [WORD_W-1:0] wr_data;
  logic              start;
  logic [LEN_W-1:0]  layer_len;
  logic              bit_en;
  logic [CH-1:0]     bit_out;
  logic              bit_valid;
  logic              busy;
  logic              layer_done;
  logic              underrun;
  logic              clr_err;

  bnn_weight_streamer #(.CH(CH), .WORD_W(WORD_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rstn(rstn), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch),
    .wr_data(wr_data), .start(start), .layer_len(layer_len), .bit_en(bit_en),
    .bit_out(bit_out), .bit_valid(bit_valid), .busy(busy), .layer_done(layer_done),
    .underrun(underrun), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] bits;
    logic          valid;
    logic          done;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mw [CH][16];
  int          mh [CH];
  int          mt [CH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] wdata(input int c, input int w);
    logic [31:0] base;
    logic [31:0] mix;
    base = 32'hA5A5_0000 + 32'(c) + (32'(w) << 8);
    mix  = 32'(w) * 32'h1357_0000;
    return base ^ mix;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rstn && (bit_valid || layer_done)) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {62'd0, bit_valid, layer_done}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("bit_valid", bit_valid, e.valid);
        chk("layer_done", layer_done, e.done);
        if (e.valid) chk("bit_out", bit_out, e.bits);
      end
    end
  end

  task automatic model_reset();
    sb.delete();
    for (int c = 0; c < CH; c++) begin
      mh[c] = 0;
      mt[c] = 0;
    end
  endtask

  task automatic wr(input int c, input logic [31:0] d, output bit busy_at_accept);
    int n = 0;
    wr_valid = 1'b1;
    wr_ch    = 4'(c);
    wr_data  = d;
    @(negedge clk);
    while (!wr_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    busy_at_accept = busy;
    if (!wr_ready) chk("wr_timeout", 64'd0, 64'd1);
    else begin
      mw[c][mt[c] % 16] = d;
      mt[c]++;
    end
    @(posedge clk);
    #1 wr_valid = 1'b0;
  endtask

  task automatic expect_layer(input int len);
    exp_t        e;
    logic [31:0] w;
    int          nw;
    if (len == 0) begin
      e      = '0;
      e.done = 1'b1;
      sb.push_back(e);
      return;
    end
    for (int i = 0; i < len; i++) begin
      e = '0;
      for (int c = 0; c < CH; c++) begin
        w         = mw[c][(mh[c] + i / 32) % 16];
        e.bits[c] = w[i % 32];
      end
      e.valid = 1'b1;
      e.done  = (i == len - 1);
      sb.push_back(e);
    end
    nw = (len + 31) / 32;
    for (int c = 0; c < CH; c++) mh[c] += nw;
  endtask

  task automatic pulse_start(input int len);
    layer_len = LEN_W'(len);
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc_busy;
    int streak;
    int n;
    rstn = 1'b0; wr_valid = 1'b0; wr_ch = '0; wr_data = '0; start = 1'b0;
    layer_len = '0; bit_en = 1'b0; clr_err = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_bit_out", bit_out, 0);
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_layer_done", layer_done, 0);
    chk("rst_underrun", underrun, 0);
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    chk("wr_ready_after_reset", wr_ready, 1);
    @(posedge clk); #1;

    // two full words per channel, no bubble across the word boundary
    for (int w = 0; w < 2; w++)
      for (int c = 0; c < CH; c++) wr(c, wdata(c, w), acc_busy);
    expect_layer(64);
    pulse_start(64);
    bit_en = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bit_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    streak = bit_valid ? 1 : 0;
    for (int k = 1; k < 64; k++) begin
      @(negedge clk);
      if (bit_valid) streak++;
    end
    chk("no_bubble_64", 64'(streak), 64'd64);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    @(posedge clk); #1 bit_en = 1'b0;
    wait_drain("drain_len64");

    // partial word, ignored start while busy, next layer starts on a fresh word
    for (int w = 2; w < 4; w++)
      for (int c = 0; c < CH; c++) wr(c, wdata(c, w), acc_busy);
    expect_layer(40);
    pulse_start(40);
    bit_en = 1'b1;
    repeat (10) @(posedge clk);
    #1 pulse_start(3);
    wait_drain("drain_len40");
    bit_en = 1'b0;
    @(negedge clk);
    chk("idle_after_len40", busy, 0);
    @(posedge clk); #1;
    for (int c = 0; c < CH; c++) wr(c, wdata(c, 4), acc_busy);
    expect_layer(32);
    pulse_start(32);
    bit_en = 1'b1;
    wait_drain("drain_len32");
    bit_en = 1'b0;

    // underrun with channel 9 empty
    for (int c = 0; c < CH - 1; c++) wr(c, wdata(c, 5), acc_busy);
    pulse_start(32);
    bit_en = 1'b1;
    repeat (4) @(negedge clk);
    chk("underrun_no_valid", bit_valid, 0);
    chk("underrun_set", underrun, 1);
    chk("underrun_busy", busy, 1);
    @(posedge clk); #1;
    wr(9, wdata(9, 5), acc_busy);
    expect_layer(32);
    wait_drain("drain_underrun");
    bit_en = 1'b0;
    chk("underrun_sticky", underrun, 1);
    clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    @(negedge clk);
    chk("underrun_cleared", underrun, 0);
    @(posedge clk); #1 bit_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_bit_en_no_underrun", underrun, 0);
    chk("idle_bit_en_no_busy", busy, 0);
    @(posedge clk); #1 bit_en = 1'b0;

    // FIFO full on channel 3, out-of-range channel
    for (int k = 0; k < DEPTH; k++) wr(3, wdata(3, 6 + k), acc_busy);
    @(negedge clk);
    chk("wr_ready_full", wr_ready, 0);
    @(posedge clk); #1 wr_ch = 4'd10;
    @(negedge clk);
    chk("wr_ready_ch10", wr_ready, 0);
    @(posedge clk); #1;
    for (int c = 0; c < CH; c++)
      if (c != 3) wr(c, wdata(c, 6), acc_busy);
    expect_layer(32);
    fork
      begin
        wr(3, wdata(3, 14), acc_busy);
      end
      begin
        pulse_start(32);
        bit_en = 1'b1;
        wait_drain("drain_full");
        bit_en = 1'b0;
      end
    join
    chk("ninth_accepted_while_streaming", acc_busy, 1);
    wr_ch = 4'd3;
    @(negedge clk);
    chk("wr_ready_refull", wr_ready, 0);
    @(posedge clk); #1;

    // zero-length layer
    expect_layer(0);
    pulse_start(0);
    @(negedge clk);
    chk("len0_busy", busy, 0);
    chk("len0_no_valid", bit_valid, 0);
    @(posedge clk); #1;
    wait_drain("drain_len0");

    // reset in the middle of a layer
    for (int c = 0; c < CH; c++)
      if (c != 3) wr(c, wdata(c, 15), acc_busy);
    expect_layer(32);
    pulse_start(32);
    bit_en = 1'b1;
    n = 0;
    while (sb.size() > 15 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reached_17_bits", 64'(sb.size() <= 15), 64'd1);
    @(posedge clk); #1 rstn = 1'b0;
    bit_en = 1'b0;
    @(negedge clk);
    chk("midrst_bit_out", bit_out, 0);
    chk("midrst_bit_valid", bit_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_layer_done", layer_done, 0);
    chk("midrst_underrun", underrun, 0);
    model_reset();
    @(posedge clk); #1 rstn = 1'b1;
    wr_ch = 4'd3;
    @(negedge clk);
    chk("fifo3_empty_after_reset", wr_ready, 1);
    @(posedge clk); #1;
    for (int w = 0; w < 2; w++)
      for (int c = 0; c < CH; c++) wr(c, wdata(c, 20 + w), acc_busy);
    expect_layer(48);
    pulse_start(48);
    bit_en = 1'b1;
    wait_drain("drain_after_reset");
    bit_en = 1'b0;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bnn_weight_streamer.md
Name: bnn_weight_streamer

Overview:
- Parametrised multi-channel serial weight feeder for the BNN datapath.
- Buffers packed weight words per channel in per-channel FIFOs and emits one weight bit per channel per cycle, in lockstep, on consumer request. The consumer request is the fc_ivalid / weight_en style strobe.
- Replaces per-channel one-bit weight inputs (weight_fc_N_in, weight_conv_in) with one word-write port plus a configurable layer length.

Parameters:
- CH, 10, number of output channels (FC neurons or conv kernels streamed in parallel)
- WORD_W, 32, bits per packed weight word
- DEPTH, 8, words per channel FIFO (power of two, >=2)
- LEN_W, 16, width of the layer length counter

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- wr_valid  in  1  weight word write request
- wr_ready  out  1  the FIFO of wr_ch can accept a word
- wr_ch  in  $clog2(CH)  target channel of the write
- wr_data  in  WORD_W  packed weight bits, bit 0 is streamed first
- start  in  1  single-cycle pulse that begins a layer
- layer_len  in  LEN_W  number of bits per channel in the layer; sampled on start
- bit_en  in  1  consumer request for the next bit
- bit_out  out  CH  one weight bit per channel
- bit_valid  out  1  bit_out carries a consumed bit
- busy  out  1  a layer is in progress
- layer_done  out  1  single-cycle pulse marking the end of a layer
- underrun  out  1  sticky error flag
- clr_err  in  1  clears underrun

Behaviour:
- Reset (rstn low, async):
  - All FIFOs are emptied; shifters are invalid; the FSM enters IDLE.
  - bit_out=0, bit_valid=0, busy=0, layer_done=0, underrun=0.
  - wr_ready reflects empty FIFOs (1) after reset release.
  - Reset mid-layer aborts the layer and drops all buffered words.
- Write port:
  - A push occurs when wr_valid && wr_ready.
  - wr_ready = (count[wr_ch] < DEPTH), evaluated on the pre-pop count. A full FIFO therefore stalls writes even if a reload pops it in the same cycle.
  - wr_ch >= CH: wr_ready=0 and no push.
  - Writes are accepted in every state, including IDLE (preload).
- Shifters:
  - One WORD_W shift register per channel, a shared valid flag `loaded`, and a shared bit index idx (0..WORD_W-1).
  - Reload condition: !loaded && all FIFOs non-empty && state==STREAM.
  - On reload, every FIFO pops one word into its shifter; loaded<=1; idx<=0.
- FSM states:
  - IDLE: busy=0. When start && layer_len!=0: latch layer_len into a remaining counter rem and go to STREAM. When start && layer_len==0: layer_done pulses on the next cycle and the FSM stays in IDLE.
  - STREAM: busy=1. The consume, underrun and last-bit rules below apply.
  - start while busy is ignored.
- Consume (STREAM && bit_en && loaded):
  - Next cycle: bit_out[c]=shifter[c][idx] and bit_valid=1 (latency 1 cycle).
  - Each consume does rem-1 and idx+1.
  - When idx==WORD_W-1: loaded<=0. If all FIFOs are non-empty in that same cycle, the reload happens immediately (back-to-back words, no bubble).
- Underrun (STREAM && bit_en && !loaded):
  - No bit is consumed; bit_valid=0 next cycle; underrun<=1.
  - underrun stays set until clr_err or reset. If clr_err and a new underrun coincide, the set wins.
- Last bit (consume with rem==1):
  - Next cycle: bit_valid=1 and layer_done=1 together; the FSM returns to IDLE.
  - loaded<=0. Unused bits of the partial word are discarded, so the next layer starts on a word boundary.
- bit_en in IDLE is ignored (no underrun). bit_out holds its last value whenever bit_valid=0.
- Width rules: rem is LEN_W bits; a layer spans ceil(layer_len/WORD_W) words per channel.

Test Plan:
- Preload in IDLE, CH=10, WORD_W=32: write 2 words per channel (channel c word0 = 32'hA5A5_0000+c), start with layer_len=64, hold bit_en high. Required: 64 consecutive bit_valid cycles with no bubble at bit 32, LSB first, matching the packed words; layer_done on the 64th valid bit; busy drops the next cycle.
- Partial word, layer_len=40 with 2 words per channel: 40 bits are emitted. A second layer (layer_len=32) started after one more word per channel emits word1's successor from bit 0, not the leftover bits 8-31.
- Underrun: start with layer_len=32 and channel 9 empty, bit_en high. Required: bit_valid=0 and underrun=1. After writing channel 9, streaming resumes at bit 0; underrun stays 1 until a clr_err pulse.
- FIFO full: DEPTH=8, write 9 words to channel 3. Required: wr_ready=0 after the 8th push; the 9th word is accepted only after that FIFO pops during streaming.
- Boundary cases:
  - start with layer_len=0 gives a layer_done pulse 1 cycle later and no bit_valid.
  - start asserted while busy has no effect.
  - wr_ch=10 gives wr_ready=0.
- Reset mid-layer after 17 bits: all outputs return to 0 and FIFOs empty. A new preload and layer then produces a correct stream.
